rv_en_flop: RTL and testbench
=============================

Name: rv_en_flop

Overview:
- Parameterized WIDTH-bit enabled register; the common storage primitive behind register-file entries (e.g. 32x32 FP register file) and small state such as bank-id registers.
- Captures din on a rising clk edge when en is high; otherwise holds its value.
- Optionally uses an integrated latch-based clock gate for power savings.
- Cycle-level behaviour is identical with and without the clock gate.

Parameters:
- WIDTH, 1, number of bits stored; legal range 1..1024.
- RESET_VAL, 0 (WIDTH bits), value loaded into dout while rst is asserted.

Ports:
- clk  input  1  single free-running clock; all capture on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable, sampled at rising clk.
- din  input  WIDTH  data to capture.
- scan_mode  input  1  test mode; forces capture every edge.
- dout  output  WIDTH  registered data.

Behaviour:
- Reset:
  - rst=1 forces dout=RESET_VAL immediately, with no clock needed.
  - While rst=1, en, din and scan_mode are ignored.
- Reset release: dout keeps RESET_VAL until the first rising clk edge after rst falls at which (en|scan_mode)=1.
- Capture: at a rising clk edge with rst=0 and (en|scan_mode)=1, dout takes din. Latency is 1 cycle; the new value is visible after the edge.
- Hold: at a rising clk edge with rst=0 and en=0 and scan_mode=0, dout is unchanged.
- Enable timing: en and din must be stable around the rising edge. A glitch on en while clk is high has no effect, in either build.
- Combinational paths: none from any input to dout except rst to dout.
- WIDTH=1 is legal, and RESET_VAL is truncated or zero-extended to WIDTH.
- Enable X-state: if en=X at an edge, the result is undefined. No correction logic is required.
- Simultaneous events: rst asserted at the same edge as en=1 gives dout=RESET_VAL, because reset wins.

Optional Feature:
- Macro: RV_EN_FLOP_CLKGATE_EN.
- Defined:
  - The storage flops are clocked by an internal gated clock, gclk = clk & en_lat.
  - en_lat is a latch that is transparent while clk is low and captures (en|scan_mode).
  - The flops load din on every gclk edge; there is no feedback mux.
  - No gclk pulse occurs when (en|scan_mode)=0.
- Undefined:
  - The flops run on clk directly, with a feedback mux: next = (en|scan_mode) ? din : dout.
- Both builds: identical dout waveform at every rising clk edge, identical reset behaviour, identical port list.

Test Plan:
- Reset (WIDTH=32, RESET_VAL=0): assert rst mid-cycle with dout=0xDEADBEEF. dout=0 immediately, before the next edge, and stays 0 while rst=1 even with en=1, din=0x12345678.
- Capture and hold (WIDTH=32): cycle 1 en=1, din=0xA5A5A5A5 gives dout=0xA5A5A5A5 after the edge. Cycles 2-4 en=0, din=0xFFFFFFFF: dout stays 0xA5A5A5A5.
- Back-to-back (WIDTH=32): en=1 for 3 edges with din=1,2,3 gives dout=1,2,3 on consecutive cycles.
- Scan override: en=0, scan_mode=1, din=0x0F0F0F0F gives dout=0x0F0F0F0F after one edge. scan_mode=0, en=0, din=0 then holds 0x0F0F0F0F.
- WIDTH=1, RESET_VAL=1: after reset dout=1. en=1, din=0 gives dout=0. Pulse en high only while clk is high (no edge) and dout is unchanged.
- Run all above with RV_EN_FLOP_CLKGATE_EN defined and undefined. The dout traces must be cycle-identical between the two builds.

Source files
------------

// File: rtl/rv_en_flop.sv
// rv_en_flop: WIDTH-bit enabled register with asynchronous active-high reset.
// The register captures din on a rising clk edge when (en | scan_mode) is high.
// Otherwise it holds its value.
// Optional build macro RV_EN_FLOP_CLKGATE_EN:
//   - Defined: the storage flops run on a latch-based gated clock and have no
//     feedback mux.
//   - Undefined: the storage flops run on clk with a hold mux.
// Both builds produce the same dout at every rising clk edge and have the same
// reset behaviour.
module rv_en_flop #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             scan_mode,
  output logic [WIDTH-1:0] dout
);

  // Scan mode forces a capture on every edge, so it folds into the enable.
  logic             load;
  logic [WIDTH-1:0] dout_reg;

  assign load = en | scan_mode;

`ifdef RV_EN_FLOP_CLKGATE_EN

  logic en_lat;
  logic gclk;

  // Enable latch: transparent while clk is low, so a glitch on en during the
  // high phase cannot create or remove a gclk pulse.
  always_latch begin
    if (!clk) begin
      en_lat = load;
    end
  end

  assign gclk = clk & en_lat;

  // Storage loads din on every gated edge; reset stays asynchronous.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      dout_reg <= RESET_VAL;
    end else begin
      dout_reg <= din;
    end
  end

`else

  logic [WIDTH-1:0] dout_next;

  // Per-bit hold mux: take din when loading, otherwise recirculate.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_next
    assign dout_next[gi] = load ? din[gi] : dout_reg[gi];
  end

  // Storage on the free-running clock with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg <= RESET_VAL;
    end else begin
      dout_reg <= dout_next;
    end
  end

`endif

  assign dout = dout_reg;

endmodule

// File: tb/tb_rv_en_flop.sv
// Directed self-checking bench for rv_en_flop.
// It instantiates a 32-bit register with reset value 0 and a 1-bit register
// with reset value 1.
// The expected values are hand-computed and are the same for both clock-gate
// builds.
module tb_rv_en_flop;

  logic        clk;
  logic        rst_a;
  logic        en_a;
  logic        scan_a;
  logic [31:0] din_a;
  logic [31:0] dout_a;
  logic        rst_b;
  logic        en_b;
  logic        scan_b;
  logic        din_b;
  logic        dout_b;

  int checks;
  int errors;

  rv_en_flop #(.WIDTH(32), .RESET_VAL(32'h0)) u_dut32 (
    .clk       (clk),
    .rst       (rst_a),
    .en        (en_a),
    .din       (din_a),
    .scan_mode (scan_a),
    .dout      (dout_a)
  );

  rv_en_flop #(.WIDTH(1), .RESET_VAL(1'b1)) u_dut1 (
    .clk       (clk),
    .rst       (rst_b),
    .en        (en_b),
    .din       (din_b),
    .scan_mode (scan_b),
    .dout      (dout_b)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (clk is high then).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1; en_a = 1'b0; scan_a = 1'b0; din_a = 32'h0;
    rst_b = 1'b1; en_b = 1'b0; scan_b = 1'b0; din_b = 1'b0;

    // Reset must act with no clock edge at all.
    #1;
    check("a_reset_noclk", dout_a, 32'h0);
    check("b_reset_noclk", {31'b0, dout_b}, 32'h1);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // First edge after release with en=0 keeps the reset value.
    tick();
    check("a_release_hold", dout_a, 32'h0);
    check("b_release_hold", {31'b0, dout_b}, 32'h1);

    // Load DEADBEEF, then assert reset in the middle of the cycle.
    en_a = 1'b1; din_a = 32'hDEADBEEF;
    tick();
    check("a_load_deadbeef", dout_a, 32'hDEADBEEF);
    din_a = 32'h12345678;
    #2;
    rst_a = 1'b1;
    #1;
    check("a_rst_midcycle", dout_a, 32'h0);
    tick();
    check("a_rst_with_en", dout_a, 32'h0);
    tick();
    check("a_rst_with_en2", dout_a, 32'h0);
    rst_a = 1'b0; en_a = 1'b0;
    tick();
    check("a_post_rst_hold", dout_a, 32'h0);

    // Capture and hold.
    en_a = 1'b1; din_a = 32'hA5A5A5A5;
    tick();
    check("a_capture", dout_a, 32'hA5A5A5A5);
    en_a = 1'b0; din_a = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("a_hold_%0d", i), dout_a, 32'hA5A5A5A5);
    end

    // Back-to-back captures.
    en_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      din_a = 32'(i);
      tick();
      check($sformatf("a_b2b_%0d", i), dout_a, 32'(i));
    end
    en_a = 1'b0;

    // Scan override, then hold.
    scan_a = 1'b1; din_a = 32'h0F0F0F0F;
    tick();
    check("a_scan_capture", dout_a, 32'h0F0F0F0F);
    scan_a = 1'b0; din_a = 32'h0;
    tick();
    check("a_scan_hold", dout_a, 32'h0F0F0F0F);
    tick();
    check("a_scan_hold2", dout_a, 32'h0F0F0F0F);

    // 1-bit instance: capture 0, then an en pulse only while clk is high.
    en_b = 1'b1; din_b = 1'b0;
    tick();
    check("b_capture0", {31'b0, dout_b}, 32'h0);
    en_b = 1'b0; din_b = 1'b1;
    tick();
    check("b_hold", {31'b0, dout_b}, 32'h0);
    en_b = 1'b1;
    #2;
    en_b = 1'b0;
    #1;
    check("b_glitch_now", {31'b0, dout_b}, 32'h0);
    tick();
    check("b_glitch_after_edge", {31'b0, dout_b}, 32'h0);

    // Scan on the 1-bit instance captures the pending 1.
    scan_b = 1'b1;
    tick();
    check("b_scan_capture", {31'b0, dout_b}, 32'h1);
    scan_b = 1'b0; din_b = 1'b0;
    tick();
    check("b_scan_hold", {31'b0, dout_b}, 32'h1);

    // Reset wins over an active enable at the edge.
    en_b = 1'b1; din_b = 1'b0; rst_b = 1'b1;
    tick();
    check("b_rst_wins", {31'b0, dout_b}, 32'h1);
    rst_b = 1'b0; en_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
